bcd_xs3_stream_conv: RTL and testbench

Multi-digit, digit-serial code converter between packed BCD and excess-3 (XS3), with a per-word direction select and per-digit invalid-code flags. Accepts one packed word of `DIGITS` nibbles over a valid/ready handshake and converts one digit per clock, least-significant digit first. Holds the result until the downstream side accepts it. Sits between the keypad/display datapaths and any XS3-based arithmetic stage. Replaces fixed single-digit combinational conversion.

---
 rtl/bcd_pkg.sv | 7 +
 rtl/bcd_xs3_stream_conv_if.sv | 8 +
 rtl/xs3_digit.sv | 14 +
 rtl/bcd_xs3_stream_conv.sv | 60 ++++++
 tb/tb_bcd_xs3_stream_conv.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared mode codes, FSM states and the XS3 bias for the BCD/XS3 converter
package bcd_pkg;
  localparam logic MODE_BCD2XS3 = 1'b0;
  localparam logic MODE_XS32BCD = 1'b1;
  localparam logic [3:0] XS3_OFFSET = 4'd3;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/bcd_xs3_stream_conv_if.sv
// bcd_xs3_stream_conv_if: word-level valid/ready bundle between upstream, converter and downstream
interface bcd_xs3_stream_conv_if #(parameter int DIGITS = 4);
  logic in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [4*DIGITS-1:0] in_data, out_data;
  logic [DIGITS-1:0] out_err;
  modport master(output in_valid, in_mode, in_data, out_ready, input in_ready, out_valid, out_data, out_err, out_mode);
  modport slave(input in_valid, in_mode, in_data, out_ready, output in_ready, out_valid, out_data, out_err, out_mode);
endinterface

// File: rtl/xs3_digit.sv
// xs3_digit: single-nibble BCD<->XS3 conversion with invalid-code detection
module xs3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       mode,
  output logic [3:0] q,
  output logic       err
);
  always_comb begin
    err = (mode == MODE_BCD2XS3) ? (d > 4'd9) : (d < 4'd3 || d > 4'd12);
    q = err ? 4'h0 : (mode == MODE_BCD2XS3) ? d + XS3_OFFSET : d - XS3_OFFSET;
  end
endmodule

// File: rtl/bcd_xs3_stream_conv.sv
// bcd_xs3_stream_conv: digit-serial packed BCD<->XS3 word converter, LSD first, valid/ready on both sides
module bcd_xs3_stream_conv
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_xs3_stream_conv_if.slave   bus,
  output logic                   busy
);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] src, res;
  logic [DIGITS-1:0] err;
  logic mode, last, dig_err;
  logic [3:0] dig_q;
  xs3_digit u_digit (
    .d    (src[{cnt, 2'b00} +: 4]),
    .mode (mode),
    .q    (dig_q),
    .err  (dig_err)
  );
  assign last = cnt == CW'(DIGITS - 1);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && bus.in_valid) ? CONV :
               (state == CONV && last) ? DONE :
               (state == DONE && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      src <= '0;
      res <= '0;
      err <= '0;
      mode <= MODE_BCD2XS3;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        src <= bus.in_data;
        mode <= bus.in_mode;
        cnt <= '0;
        res <= '0;
        err <= '0;
      end else if (state == CONV) begin
        res[{cnt, 2'b00} +: 4] <= dig_q;
        err[cnt] <= dig_err;
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign busy = state != IDLE;
  assign bus.out_data = res;
  assign bus.out_err = err;
  assign bus.out_mode = mode;
endmodule

// File: tb/tb_bcd_xs3_stream_conv.sv
// tb_bcd_xs3_stream_conv: directed and randomized checks of the converter against a per-digit arithmetic model
module tb_bcd_xs3_stream_conv;
  logic clk = 0, rst_n = 0, busy;
  int n_checks = 0, n_fail = 0, cyc = 0;
  bcd_xs3_stream_conv_if #(.DIGITS(4)) bus();
  bcd_xs3_stream_conv #(.DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [15:0] d, input logic m, output logic [15:0] r, output logic [3:0] e);
    for (int i = 0; i < 4; i++) begin
      int v;
      bit bad;
      v = int'(d[4*i +: 4]);
      bad = m ? (v < 3 || v > 12) : (v > 9);
      e[i] = bad;
      r[4*i +: 4] = bad ? 4'h0 : 4'((m ? v - 3 : v + 3) % 16);
    end
  endfunction

  task automatic run_word(input logic [15:0] d, input logic m, input bit release_out,
                          output logic [15:0] od, output logic [3:0] oe, output logic om, output int lat);
    int n;
    bus.in_data = d;
    bus.in_mode = m;
    bus.in_valid = 1;
    bus.out_ready = 0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    od = bus.out_data;
    oe = bus.out_err;
    om = bus.out_mode;
    if (release_out) begin
      bus.out_ready = 1;
      @(posedge clk); #1;
      bus.out_ready = 0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] din[7] = '{16'h1234, 16'h9A05, 16'h9999, 16'h4567, 16'hCCCC, 16'h0333, 16'hD302};
    logic        min[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] dex[7] = '{16'h4567, 16'hC038, 16'hCCCC, 16'h1234, 16'h9999, 16'h0000, 16'h0000};
    logic [3:0]  eex[7] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1011};
    logic [15:0] od;
    logic [3:0] oe;
    logic om;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_word(din[i], min[i], 1'b1, od, oe, om, lat);
      n_checks++; if (od !== dex[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h expected %h", i, od, dex[i]); end
      n_checks++; if (oe !== eex[i]) begin n_fail++; $display("FAIL dir%0d_err: got %b expected %b", i, oe, eex[i]); end
      n_checks++; if (om !== min[i]) begin n_fail++; $display("FAIL dir%0d_mode: got %b expected %b", i, om, min[i]); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] od, rex;
    logic [3:0] oe, eex;
    logic om;
    int lat;
    model(16'h2468, 1'b1, rex, eex);
    run_word(16'h2468, 1'b1, 1'b0, od, oe, om, lat);
    bus.in_data = 16'h5555;
    bus.in_mode = 1'b0;
    bus.in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_data !== rex) begin n_fail++; $display("FAIL bp_data: got %h expected %h", bus.out_data, rex); end
      n_checks++; if (bus.out_err !== eex) begin n_fail++; $display("FAIL bp_err: got %b expected %b", bus.out_err, eex); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
    n_checks++; if (bus.out_data !== rex) begin n_fail++; $display("FAIL bp_not_captured: got %h expected %h", bus.out_data, rex); end
  endtask

  task automatic test_reset_mid_conv();
    logic [15:0] od;
    logic [3:0] oe;
    logic om;
    int lat;
    bus.in_data = 16'h1234;
    bus.in_mode = 1'b0;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    n_checks++; if ({bus.out_valid, bus.out_data, bus.out_err, bus.out_mode, busy} !== 23'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got v=%b d=%h e=%b m=%b busy=%b expected all 0", bus.out_valid, bus.out_data, bus.out_err, bus.out_mode, busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
    #1 rst_n = 1;
    @(posedge clk); #1;
    run_word(16'h0000, 1'b0, 1'b1, od, oe, om, lat);
    n_checks++; if (od !== 16'h3333) begin n_fail++; $display("FAIL rst_after_data: got %h expected 3333", od); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rst_after_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, rex;
    logic [3:0] eex;
    logic m;
    int n, lat, acc, prev;
    bus.out_ready = 1;
    bus.in_valid = 1;
    prev = 0;
    for (int w = 0; w < 6; w++) begin
      m = (w % 2) == 1;
      d = 16'($urandom);
      model(d, m, rex, eex);
      bus.in_data = d;
      bus.in_mode = m;
      n = 0;
      while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      acc = cyc;
      if (w > 0) begin
        n_checks++; if (acc - prev !== 6) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 6", acc - prev); end
      end
      prev = acc;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_checks++; if (bus.out_data !== rex) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", bus.out_data, rex); end
      n_checks++; if (bus.out_err !== eex) begin n_fail++; $display("FAIL b2b_err: got %b expected %b", bus.out_err, eex); end
      n_checks++; if (bus.out_mode !== m) begin n_fail++; $display("FAIL b2b_mode: got %b expected %b", bus.out_mode, m); end
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 0;
  endtask

  task automatic test_random();
    logic [15:0] d, od, rex;
    logic [3:0] oe, eex;
    logic m, om;
    int lat;
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      m = 1'($urandom_range(1));
      model(d, m, rex, eex);
      run_word(d, m, 1'b1, od, oe, om, lat);
      n_checks++; if (od !== rex) begin n_fail++; $display("FAIL rand_data: in %h mode %b got %h expected %h", d, m, od, rex); end
      n_checks++; if (oe !== eex) begin n_fail++; $display("FAIL rand_err: in %h mode %b got %b expected %b", d, m, oe, eex); end
      n_checks++; if (om !== m) begin n_fail++; $display("FAIL rand_mode: got %b expected %b", om, m); end
    end
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_mode = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_conv();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
